// File: rtl/wb_cache_ctrl.sv
// wb_cache_ctrl: direct-mapped, write-back, write-allocate cache with one
// data word per line. Tag/data storage is held in arrays with a registered
// read; valid/dirty bits are flops so reset can clear them in one cycle.
// The controller FSM handles hits, dirty-line write-back and line refill.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
module wb_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        FILL_REQ,
        FILL_WAIT
    } state_t;

    state_t             r_state;
    logic               r_we;
    logic [TAG_W-1:0]   r_tag;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rd_data;
    logic [TAG_W-1:0]   r_rd_tag;
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic               r_resp_valid;
    logic [DATA_W-1:0]  r_resp_rdata;
    logic               r_mem_req_valid;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;

    logic [DATA_W-1:0]  r_data_mem [LINES];
    logic [TAG_W-1:0]   r_tag_mem  [LINES];

    logic [IDX_W-1:0]   w_req_idx;
    logic [TAG_W-1:0]   w_req_tag;
    logic               w_accept;
    logic               w_fill;
    logic               w_hit;
    logic               w_store_hit;

    assign w_req_idx   = req_addr[OFF_W +: IDX_W];
    assign w_req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_fill      = (r_state == FILL_WAIT) && mem_resp_valid;
    assign w_hit       = r_valid[r_idx] && (r_rd_tag == r_tag);
    assign w_store_hit = (r_state == LOOKUP) && w_hit && r_we;

    assign req_ready     = (r_state == IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

    // Byte-offset bits of the request address do not select anything.
    generate
        if (OFF_W > 0) begin : g_off
            logic w_unused_off;
            assign w_unused_off = ^req_addr[OFF_W-1:0];
        end
    endgenerate

    // Build a word-aligned memory address from a tag and an index.
    function automatic logic [ADDR_W-1:0] f_addr(input logic [TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[ADDR_W-1 -: TAG_W] = tag;
        a[OFF_W +: IDX_W]    = idx;
        return a;
    endfunction

    // Tag/data array writes: refill installs the line, a store hit merges data.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data_mem[r_idx] <= mem_rdata;
            r_tag_mem[r_idx]  <= r_tag;
        end else if (w_store_hit) begin
            r_data_mem[r_idx] <= r_wdata;
        end
    end

    // Registered array read at accept; a refill forwards the new line so the
    // re-lookup sees it without another read cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rd_data <= r_data_mem[w_req_idx];
            r_rd_tag  <= r_tag_mem[w_req_idx];
        end else if (w_fill) begin
            r_rd_data <= mem_rdata;
            r_rd_tag  <= r_tag;
        end
    end

    // Per-line valid and dirty flags.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line
            // Refill marks the line valid and clean; a store hit dirties it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid[gi] <= 1'b0;
                    r_dirty[gi] <= 1'b0;
                end else if (w_fill && (r_idx == IDX_W'(gi))) begin
                    r_valid[gi] <= 1'b1;
                    r_dirty[gi] <= 1'b0;
                end else if (w_store_hit && (r_idx == IDX_W'(gi))) begin
                    r_dirty[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Controller FSM with registered CPU and memory-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_we            <= 1'b0;
            r_tag           <= '0;
            r_idx           <= '0;
            r_wdata         <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_tag   <= w_req_tag;
                        r_idx   <= w_req_idx;
                        r_wdata <= req_wdata;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_we ? '0 : r_rd_data;
                        r_state      <= IDLE;
                    end else if (r_valid[r_idx] && r_dirty[r_idx]) begin
                        r_mem_req_valid <= 1'b1;
                        r_mem_we        <= 1'b1;
                        r_mem_addr      <= f_addr(r_rd_tag, r_idx);
                        r_mem_wdata     <= r_rd_data;
                        r_state         <= WB_REQ;
                    end else begin
                        r_mem_req_valid <= 1'b1;
                        r_mem_we        <= 1'b0;
                        r_mem_addr      <= f_addr(r_tag, r_idx);
                        r_mem_wdata     <= '0;
                        r_state         <= FILL_REQ;
                    end
                end
                WB_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= f_addr(r_tag, r_idx);
                        r_mem_wdata <= '0;
                        r_state     <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_mem_addr      <= '0;
                        r_state         <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        r_state <= LOOKUP;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic        r_first;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Count each request once, at its first lookup only; saturate at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_first      <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_accept) begin
                r_first <= 1'b1;
            end else if (r_state == LOOKUP) begin
                r_first <= 1'b0;
            end
            if ((r_state == LOOKUP) && r_first) begin
                if (w_hit) begin
                    if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
                end else begin
                    if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Bench for wb_cache_ctrl: directed scenarios plus randomized loads/stores,
// checked against a flat-memory reference and a line-occupancy model.
module tb_wb_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    wb_cache_ctrl dut (
        .clk(clk),
        .reset(reset),
`ifdef CACHE_STATS_EN
        .hit_count(hit_count),
        .miss_count(miss_count),
`endif
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- memory contents ----------------
    logic [31:0] bmem [logic [31:0]];   // backing store as written by the DUT
    logic [31:0] emem [logic [31:0]];   // value the CPU should observe per word

    function automatic logic [31:0] init_content(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] bmem_read(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return init_content(a);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (emem.exists(a)) return emem[a];
        return init_content(a);
    endfunction

    // ---------------- line occupancy model ----------------
    bit          mv [8];
    bit          md [8];
    logic [26:0] mt [8];
    int          m_hits;
    int          m_misses;

    // ---------------- memory responder ----------------
    int          wb_cnt = 0;
    int          fill_cnt = 0;
    logic [31:0] last_wb_addr, last_wb_data, last_fill_addr;
    bit          pend = 0;
    logic [31:0] pend_addr;
    bit          mute = 0;
    bit          stray = 0;
    int          stall_left = 0;
    logic [31:0] stall_addr = '0;

    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_rdata      = '0;
            if (stray) begin
                stray          = 0;
                mem_resp_valid = 1'b1;
                mem_rdata      = $urandom;
            end else if (pend) begin
                pend = 0;
                if (!mute) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = bmem_read(pend_addr);
                end
            end
            mem_req_ready = 1'b1;
            if (mem_req_valid && !mem_we && stall_left > 0) begin
                mem_req_ready = 1'b0;
                chk("stall_addr", mem_addr, stall_addr);
                chk("stall_no_resp", 32'(resp_valid), 32'd0);
                stall_left--;
            end
            if (mem_req_valid && mem_req_ready && !reset) begin
                if (mem_we) begin
                    bmem[mem_addr] = mem_wdata;
                    wb_cnt++;
                    last_wb_addr = mem_addr;
                    last_wb_data = mem_wdata;
                end else begin
                    fill_cnt++;
                    last_fill_addr = mem_addr;
                    pend      = 1;
                    pend_addr = mem_addr;
                end
            end
        end
    end

    task automatic chk_counters();
`ifdef CACHE_STATS_EN
        chk("hit_count", hit_count, 32'(m_hits));
        chk("miss_count", miss_count, 32'(m_misses));
`endif
    endtask

    // One CPU transaction, checked against the reference models.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall);
        logic [31:0] w, wb_a, wb_d, exp_rd, rd;
        logic [2:0]  idx;
        logic [26:0] tag;
        bit          hit, evict;
        int          exp_lat, lat, wb0, f0, eff_stall;
        w       = addr & 32'hFFFF_FFFC;
        idx     = w[4:2];
        tag     = w[31:5];
        hit     = mv[idx] && (mt[idx] == tag);
        evict   = !hit && mv[idx] && md[idx];
        wb_a    = {mt[idx], idx, 2'b00};
        wb_d    = exp_read(wb_a);
        exp_rd  = exp_read(w);
        eff_stall = hit ? 0 : stall;
        exp_lat = hit ? 1 : ((evict ? 5 : 4) + eff_stall);
        wb0 = wb_cnt;
        f0  = fill_cnt;

        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        stall_left = eff_stall;
        stall_addr = w;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = -1;
        rd  = '0;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            if (resp_valid) begin
                lat = n - 1;
                rd  = resp_rdata;
                break;
            end
            if (n == 1) chk("rdata_zero_idle", resp_rdata, 32'd0);
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (lat >= 0) chk("req_ready_at_resp", 32'(req_ready), 32'd1);
        if (!we) chk("load_data", rd, exp_rd);
        chk("wb_count", 32'(wb_cnt - wb0), 32'(evict));
        if (evict) begin
            chk("wb_addr", last_wb_addr, wb_a);
            chk("wb_data", last_wb_data, wb_d);
        end
        chk("fill_count", 32'(fill_cnt - f0), 32'(!hit));
        if (!hit) chk("fill_addr", last_fill_addr, w);

        if (hit) m_hits++; else m_misses++;
        if (!hit) begin
            mv[idx] = 1;
            md[idx] = 0;
            mt[idx] = tag;
        end
        if (we) begin
            md[idx] = 1;
            emem[w] = wdata;
        end
        chk_counters();
        $display("TXN %s addr=%h wdata=%h rdata=%h lat=%0d exp_lat=%0d %s",
                 we ? "ST" : "LD", addr, wdata, rd, lat, exp_lat, hit ? "hit" : "miss");
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 0;
            md[i] = 0;
            mt[i] = '0;
        end
        m_hits   = 0;
        m_misses = 0;
        emem.delete();
        foreach (bmem[a]) emem[a] = bmem[a];
    endtask

    initial begin
        int          pulses;
        int          f0;
        bit          seen;
        logic [31:0] a;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk_counters();

        // Clean miss then hit on 0x40
        do_req(0, 32'h0000_0040, 32'h0, 0);
        do_req(0, 32'h0000_0040, 32'h0, 0);
        // Store hit, then same-index load forces a write-back
        do_req(1, 32'h0000_0040, 32'h1111_2222, 0);
        do_req(0, 32'h0000_0060, 32'h0, 0);
        // Fill request held off for 5 cycles
        do_req(0, 32'h0000_0088, 32'h0, 5);
        // Store miss with write-allocate, read back, then evict
        do_req(1, 32'h0000_0084, 32'hA5A5_A5A5, 0);
        do_req(0, 32'h0000_0084, 32'h0, 0);
        do_req(0, 32'h0000_00A4, 32'h0, 0);

        // Reset while waiting for refill data
        mute = 1;
        f0   = fill_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_000C;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            if (fill_cnt != f0) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("fill_issued_before_reset", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mute  = 0;
        pend  = 0;
        model_reset();
        chk("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk_counters();
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            if (resp_valid) pulses++;
            @(negedge clk);
        end
        chk("midrst_no_resp", 32'(pulses), 32'd0);
        do_req(0, 32'h0000_000C, 32'h0, 0);

        // Stray refill pulse while idle
        do_req(0, 32'h0000_0084, 32'h0, 0);
        stray = 1;
        pulses = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (resp_valid || !req_ready || mem_req_valid) pulses++;
        end
        chk("stray_no_effect", 32'(pulses), 32'd0);
        do_req(0, 32'h0000_0084, 32'h0, 0);

        // Randomized traffic over a small address window
        for (int t = 0; t < 150; t++) begin
            a = (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
